// File: rtl/traffic_pkg.sv
// Light-code constants and the cycle-legality rule, shared with the light
// controller so that both sides of the intersection agree on the encoding.
package traffic_pkg;

  localparam logic [1:0] GREEN   = 2'b00;
  localparam logic [1:0] YELLOW  = 2'b01;
  localparam logic [1:0] RED     = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;

  // A cycle is legal only when at least one street is held at red and
  // neither street shows the reserved code.
  function automatic logic cycle_legal(input logic [1:0] la, input logic [1:0] lb);
    return ((la == RED) || (lb == RED)) && (la != ILLEGAL) && (lb != ILLEGAL);
  endfunction

endpackage

// File: rtl/street_queue.sv
// One street's waiting line: queue depth with saturation, departed-car
// counter that wraps, and a sticky flag for arrivals dropped on a full queue.
module street_queue
  import traffic_pkg::*;
#(
  parameter int QW = 4,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arrive,   // one car joins the line this cycle
  input  logic          go,       // street has a legal green this cycle
  output logic [QW-1:0] q,
  output logic [PW-1:0] passed,
  output logic          ovf
);

  localparam logic [QW-1:0] Q_MAX = '1;

  logic depart;

  // A car leaves only if someone was already waiting at the edge, so an
  // arrival on an empty queue under green has to wait for the next edge.
  assign depart = go && (q != '0);

  // Queue depth: arrive and depart together cancel; arrival on a full queue
  // with no departure is dropped and recorded in the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      ovf <= 1'b0;
    end else begin
      if (arrive && !depart) begin
        if (q == Q_MAX) begin
          ovf <= 1'b1;
        end else begin
          q <= q + 1'b1;
        end
      end else if (!arrive && depart) begin
        q <= q - 1'b1;
      end
    end
  end

  // Departed-car count, wrapping silently modulo 2^PW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      passed <= '0;
    end else if (depart) begin
      passed <= passed + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_street_model.sv
// Road side of a two-street intersection: consumes light codes, queues
// arriving cars, releases them on legal green and drives the traffic-present
// sensors Ta/Tb back to the light controller.
module traffic_street_model
  import traffic_pkg::*;
#(
  parameter int QW = 4,
  parameter int PW = 8
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic [1:0]    La,
  input  logic [1:0]    Lb,
  input  logic          ArrA,
  input  logic          ArrB,
  output logic          Ta,
  output logic          Tb,
  output logic [QW-1:0] QA,
  output logic [QW-1:0] QB,
  output logic [PW-1:0] PassedA,
  output logic [PW-1:0] PassedB,
  output logic          Conflict,
  output logic          Overflow
);

  logic legal;
  logic ovf_a;
  logic ovf_b;

  assign legal = cycle_legal(La, Lb);

  street_queue #(.QW(QW), .PW(PW)) u_street_a (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .arrive (ArrA),
    .go     (legal && (La == GREEN)),
    .q      (QA),
    .passed (PassedA),
    .ovf    (ovf_a)
  );

  street_queue #(.QW(QW), .PW(PW)) u_street_b (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .arrive (ArrB),
    .go     (legal && (Lb == GREEN)),
    .q      (QB),
    .passed (PassedB),
    .ovf    (ovf_b)
  );

  // Sensors come from registered queue depth only, never from the inputs.
  assign Ta       = (QA != '0);
  assign Tb       = (QB != '0);
  assign Overflow = ovf_a || ovf_b;

  // Sticky conflict flag: set at the edge after any illegal light pair.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Conflict <= 1'b0;
    end else if (!legal) begin
      Conflict <= 1'b1;
    end
  end

endmodule

// File: tb/tb_traffic_street_model.sv
// Bench for traffic_street_model: directed scenarios plus randomized light
// and arrival traffic, checked against a counting model of the two streets.
module tb_traffic_street_model;
  import traffic_pkg::*;

  localparam int QW    = 4;
  localparam int PW    = 8;
  localparam int Q_MAX = (1 << QW) - 1;
  localparam int P_MOD = (1 << PW);

  logic          Clk;
  logic          Rst_n;
  logic [1:0]    La;
  logic [1:0]    Lb;
  logic          ArrA;
  logic          ArrB;
  logic          Ta;
  logic          Tb;
  logic [QW-1:0] QA;
  logic [QW-1:0] QB;
  logic [PW-1:0] PassedA;
  logic [PW-1:0] PassedB;
  logic          Conflict;
  logic          Overflow;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // reference state: plain integers per street
  int mq_a, mq_b, mp_a, mp_b;
  bit m_conf, m_ovf;

  traffic_street_model #(.QW(QW), .PW(PW)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .La       (La),
    .Lb       (Lb),
    .ArrA     (ArrA),
    .ArrB     (ArrB),
    .Ta       (Ta),
    .Tb       (Tb),
    .QA       (QA),
    .QB       (QB),
    .PassedA  (PassedA),
    .PassedB  (PassedB),
    .Conflict (Conflict),
    .Overflow (Overflow)
  );

  // clock / reset block
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq_a = 0; mq_b = 0; mp_a = 0; mp_b = 0;
    m_conf = 0; m_ovf = 0;
  endtask

  // One street for one edge, from the traffic rules directly.
  task automatic street_step(input bit legal, input logic [1:0] light, input logic arr,
                             inout int q, inout int p);
    bit dep;
    dep = legal && (light == GREEN) && (q > 0);
    if (arr && !dep && q == Q_MAX) m_ovf = 1;
    else q = q + int'(arr) - int'(dep);
    if (dep) p = (p + 1) % P_MOD;
  endtask

  task automatic model_step(input logic [1:0] la, input logic [1:0] lb,
                            input logic aa, input logic ab);
    bit legal;
    legal = (la == RED || lb == RED) && la != ILLEGAL && lb != ILLEGAL;
    street_step(legal, la, aa, mq_a, mp_a);
    street_step(legal, lb, ab, mq_b, mp_b);
    if (!legal) m_conf = 1;
  endtask

  task automatic check_all(input string ctx);
    check_val({ctx, ".QA"},       32'(QA),       32'(mq_a));
    check_val({ctx, ".QB"},       32'(QB),       32'(mq_b));
    check_val({ctx, ".Ta"},       32'(Ta),       32'(mq_a != 0));
    check_val({ctx, ".Tb"},       32'(Tb),       32'(mq_b != 0));
    check_val({ctx, ".PassedA"},  32'(PassedA),  32'(mp_a));
    check_val({ctx, ".PassedB"},  32'(PassedB),  32'(mp_b));
    check_val({ctx, ".Conflict"}, 32'(Conflict), 32'(m_conf));
    check_val({ctx, ".Overflow"}, 32'(Overflow), 32'(m_ovf));
  endtask

  // driver: apply inputs for one cycle, step model at the edge, check after it
  task automatic drive_cycle(input logic [1:0] la, input logic [1:0] lb,
                             input logic aa, input logic ab, input string ctx);
    La = la; Lb = lb; ArrA = aa; ArrB = ab;
    @(posedge Clk);
    model_step(la, lb, aa, ab);
    #1;
    check_all(ctx);
  endtask

  // Asynchronous reset mid-cycle; arrivals and green held during reset
  // must not be counted.
  task automatic do_reset(input string ctx);
    #2;
    Rst_n = 1'b0;
    #1;
    model_clear();
    check_all({ctx, ".async"});
    La = GREEN; Lb = RED; ArrA = 1'b1; ArrB = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check_all({ctx, ".held"});
    @(negedge Clk);
    Rst_n = 1'b1;
    ArrA = 1'b0; ArrB = 1'b0; La = RED; Lb = RED;
  endtask

  initial begin
    logic [1:0] la, lb;
    Rst_n = 1'b0; La = RED; Lb = RED; ArrA = 1'b0; ArrB = 1'b0;
    model_clear();
    #12;
    check_all("reset0");
    @(negedge Clk);
    Rst_n = 1'b1;

    // three arrivals on A while A is red
    for (int i = 0; i < 3; i++) drive_cycle(RED, GREEN, 1'b1, 1'b0, "fillA");
    check_val("fillA.QA3", 32'(QA), 32'd3);
    check_val("fillA.Ta", 32'(Ta), 32'd1);

    // A green drains three cars
    for (int i = 0; i < 3; i++) drive_cycle(GREEN, RED, 1'b0, 1'b0, "drainA");
    check_val("drainA.PassedA3", 32'(PassedA), 32'd3);
    check_val("drainA.Ta0", 32'(Ta), 32'd0);

    // saturate B, then accept arrivals while departing at full queue
    for (int i = 0; i < 16; i++) drive_cycle(RED, RED, 1'b0, 1'b1, "fillB");
    check_val("fillB.QB15", 32'(QB), 32'd15);
    check_val("fillB.Overflow", 32'(Overflow), 32'd1);
    for (int i = 0; i < 4; i++) drive_cycle(RED, GREEN, 1'b0, 1'b1, "fullB");
    check_val("fullB.PassedB4", 32'(PassedB), 32'd4);
    check_val("fullB.QB15", 32'(QB), 32'd15);

    // both green: no departures, sticky conflict
    do_reset("rst1");
    for (int i = 0; i < 2; i++) drive_cycle(RED, RED, 1'b1, 1'b1, "prep1");
    drive_cycle(GREEN, GREEN, 1'b0, 1'b0, "bothgreen");
    check_val("bothgreen.QA2", 32'(QA), 32'd2);
    check_val("bothgreen.Conflict", 32'(Conflict), 32'd1);
    drive_cycle(RED, RED, 1'b0, 1'b0, "sticky");

    // illegal code on A blocks B's green too
    do_reset("rst2");
    for (int i = 0; i < 2; i++) drive_cycle(RED, RED, 1'b1, 1'b1, "prep2");
    drive_cycle(ILLEGAL, GREEN, 1'b0, 1'b0, "illegalA");
    check_val("illegalA.QB2", 32'(QB), 32'd2);
    check_val("illegalA.Conflict", 32'(Conflict), 32'd1);

    // 256 departures on A wrap the counter to zero
    do_reset("rst3");
    for (int i = 0; i < 257; i++) drive_cycle(GREEN, RED, 1'b1, 1'b0, "wrapA");
    check_val("wrapA.PassedA0", 32'(PassedA), 32'd0);
    check_val("wrapA.Overflow", 32'(Overflow), 32'd0);

    // reset in the middle of a green with QA=5
    do_reset("rst4");
    for (int i = 0; i < 5; i++) drive_cycle(RED, GREEN, 1'b1, 1'b0, "prep5");
    check_val("prep5.QA5", 32'(QA), 32'd5);
    La = GREEN; Lb = RED; ArrA = 1'b0;
    do_reset("midgreen");

    // randomized traffic with occasional illegal lights and resets
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 149) == 0) do_reset("rndrst");
      if ($urandom_range(0, 39) == 0) begin
        la = 2'($urandom_range(0, 3));
        lb = GREEN;
      end else if ($urandom_range(0, 1) == 1) begin
        la = RED;
        lb = 2'($urandom_range(0, 2));
      end else begin
        la = 2'($urandom_range(0, 2));
        lb = RED;
      end
      drive_cycle(la, lb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/traffic_street_model.md
TRAFFIC_STREET_MODEL -- requirements
Module: traffic_street_model

Interface
REQ-001 SHALL have parameter QW, default 4, queue counter width per street.
REQ-002 SHALL have parameter PW, default 8, passed-car counter width per street.
REQ-003 Clk  input  1  sole clock; all state updates on posedge Clk.
REQ-004 Rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 La  input  2  street-A light code: 00 green, 01 yellow, 10 red, 11 illegal.
REQ-006 Lb  input  2  street-B light code, same encoding as La.
REQ-007 ArrA  input  1  one car arrives on street A this cycle.
REQ-008 ArrB  input  1  one car arrives on street B this cycle.
REQ-009 Ta  output  1  traffic-present sensor, street A; high when QA != 0.
REQ-010 Tb  output  1  traffic-present sensor, street B; high when QB != 0.
REQ-011 QA, QB  output  QW  current queue depth per street.
REQ-012 PassedA, PassedB  output  PW  cars departed per street; wraps modulo 2^PW.
REQ-013 Conflict  output  1  sticky: illegal light combination seen.
REQ-014 Overflow  output  1  sticky: arrival dropped on a full queue.

Function
REQ-015 Block SHALL model the road side of the intersection: it consumes light codes and produces sensor inputs Ta/Tb for the light controller.
REQ-016 Ta/Tb SHALL decode combinationally from registered QA/QB only (no input-to-output path); arrival at edge n raises Ta after edge n.
REQ-017 Legal cycle: (La==10 or Lb==10) and neither code ==11; otherwise illegal.
REQ-018 Departure on street X SHALL occur at the edge iff cycle legal, light X ==00, and QX != 0.
REQ-019 Yellow (01) and red (10) SHALL block departures; illegal cycle blocks departures on both streets.
REQ-020 Queue update per edge: QX_next = QX + arrive - depart; arrive and depart together leave QX unchanged.
REQ-021 Arrival with QX == 2^QW-1 and no departure SHALL be dropped; QX holds at max; Overflow sets at that edge.
REQ-022 Arrival with QX at max and a departure in the same cycle SHALL be accepted (QX unchanged, no Overflow).
REQ-023 Arrival on empty queue under green: QX becomes 1 (departure needs QX != 0 at the edge); departs next green edge.
REQ-024 PassedX SHALL increment by 1 on every departure edge; wrap 2^PW-1 -> 0 silently.
REQ-025 Conflict SHALL set at the edge following any illegal cycle and hold until reset.
REQ-026 Overflow and Conflict SHALL remain set until reset; no clear input.
REQ-027 Streets independent: events on A SHALL never alter B state and vice versa.

Reset
REQ-028 Rst_n low SHALL immediately force QA=QB=0, PassedA=PassedB=0, Conflict=0, Overflow=0, hence Ta=Tb=0.
REQ-029 Reset asserted mid-operation SHALL discard queues and counters; no arrival/departure counted on an edge where Rst_n is low.
REQ-030 First update SHALL be the first posedge Clk after Rst_n deasserts.

Structure
REQ-031 Light-code constants (GREEN=00, YELLOW=01, RED=10, ILLEGAL=11) SHALL live in shared package traffic_pkg, shared with the light controller.
REQ-032 One sub-module street_queue (queue counter, passed counter, saturation, overflow detect) SHALL be instantiated twice; top holds legality decode and Conflict.

Verification
REQ-033 Reset, La=10 Lb=00, ArrA pulsed 3 cycles -> QA=3, Ta=1, Tb=0, PassedA=0.
REQ-034 Then La=00 Lb=10, no arrivals, 3 cycles -> QA 3,2,1,0; Ta drops after 3rd edge; PassedA=3.
REQ-035 La=10 Lb=10, ArrB held 16 cycles -> QB=15 after 15 edges, 16th arrival dropped, Overflow=1; then Lb=00 with ArrB held -> QB stays 15, PassedB increments each cycle.
REQ-036 Drive La=00 Lb=00 one cycle with QA=2, QB=2 -> no departures, Conflict=1 next edge and sticky; same for La=11.
REQ-037 Force 256 departures on A -> PassedA wraps 255 -> 0, no flag.
REQ-038 Assert Rst_n low mid-green with QA=5 -> QA=0, Ta=0, all flags 0 immediately without clock edge.
